// File: rtl/rst_sequencer_pkg.sv
// rtl/rst_sequencer_pkg.sv - shared state encoding, cause codes and widths for rst_sequencer
package rst_sequencer_pkg;

   localparam int STAGE_CNT_W = 8;
   localparam int WDT_CNT_W   = 16;

   typedef enum logic [1:0] {
      S_HOLD   = 2'd0,
      S_MEM    = 2'd1,
      S_PERIPH = 2'd2,
      S_RUN    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_POR = 2'b00,
      CAUSE_EXT = 2'b01,
      CAUSE_WDT = 2'b10,
      CAUSE_SW  = 2'b11
   } cause_e;

   typedef struct packed {
      logic mem;
      logic periph;
      logic cpu;
      logic ready;
   } dom_out_t;

   // Domain resets are a pure function of the state the sequencer is entering.
   function automatic dom_out_t domain_outputs(state_e s);
      dom_out_t d;
      d = '{mem: 1'b1, periph: 1'b1, cpu: 1'b1, ready: 1'b0};
      case (s)
         S_MEM:    d.mem = 1'b0;
         S_PERIPH: begin
            d.mem    = 1'b0;
            d.periph = 1'b0;
         end
         S_RUN:    d = '{mem: 1'b0, periph: 1'b0, cpu: 1'b0, ready: 1'b1};
         default:  ;
      endcase
      return d;
   endfunction

   function automatic state_e next_stage(state_e s);
      case (s)
         S_HOLD:   return S_MEM;
         S_MEM:    return S_PERIPH;
         default:  return S_RUN;
      endcase
   endfunction

endpackage

// File: rtl/rst_wdt.sv
// rtl/rst_wdt.sv - watchdog counter for rst_sequencer: counts run cycles, cleared by kick, pulses on expiry
module rst_wdt
   import rst_sequencer_pkg::*;
#(
   parameter int WDT_TIMEOUT = 65535
) (
   input  logic clk,
   input  logic rst_n_i,
   input  logic run_i,
   input  logic kick_i,
   output logic expire_o
);

   localparam logic [WDT_CNT_W-1:0] WDT_LAST = WDT_CNT_W'(WDT_TIMEOUT - 1);

   logic [WDT_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (!run_i || kick_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + WDT_CNT_W'(1);
      end
   end

   // Leaving S_RUN on the expiry edge clears the counter, so this is a one-cycle pulse.
   assign expire_o = run_i && (cnt_q == WDT_LAST);

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged mem/periph/cpu reset release with cause tracking; watchdog under RST_SEQ_WDT_EN
module rst_sequencer
   import rst_sequencer_pkg::*;
#(
   parameter int DELAY       = 16,
   parameter int WDT_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       rst_n_i,
   input  logic       rst_req_i,
   input  logic       sw_rst_i,
   input  logic       wdt_kick_i,
   output logic       rst_mem_o,
   output logic       rst_periph_o,
   output logic       rst_cpu_o,
   output logic       ready_o,
   output logic [1:0] rst_cause_o
);

   localparam logic [STAGE_CNT_W-1:0] STAGE_LAST = STAGE_CNT_W'(DELAY - 1);

   state_e                 state_q, state_d;
   logic [STAGE_CNT_W-1:0] cnt_q, cnt_d;
   cause_e                 cause_q, cause_d;
   dom_out_t               out_q;
   logic                   wdt_exp;
   logic                   req;

`ifdef RST_SEQ_WDT_EN
   rst_wdt #(
      .WDT_TIMEOUT(WDT_TIMEOUT)
   ) u_wdt (
      .clk     (clk),
      .rst_n_i (rst_n_i),
      .run_i   (state_q == S_RUN),
      .kick_i  (wdt_kick_i),
      .expire_o(wdt_exp)
   );
`else
   logic unused_wdt;
   assign unused_wdt = wdt_kick_i & (WDT_TIMEOUT != 0);
   assign wdt_exp    = 1'b0;
`endif

   assign req = rst_req_i | sw_rst_i | wdt_exp;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      if (req) begin
         state_d = S_HOLD;
         cnt_d   = '0;
         if (rst_req_i) begin
            cause_d = CAUSE_EXT;
         end else if (wdt_exp) begin
            cause_d = CAUSE_WDT;
         end else begin
            cause_d = CAUSE_SW;
         end
      end else begin
         case (state_q)
            S_HOLD, S_MEM, S_PERIPH: begin
               if (cnt_q == STAGE_LAST) begin
                  state_d = next_stage(state_q);
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + STAGE_CNT_W'(1);
               end
            end
            default: cnt_d = '0;
         endcase
      end
   end

   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_HOLD;
         cnt_q   <= '0;
         cause_q <= CAUSE_POR;
         out_q   <= domain_outputs(S_HOLD);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         out_q   <= domain_outputs(state_d);
      end
   end

   assign rst_mem_o    = out_q.mem;
   assign rst_periph_o = out_q.periph;
   assign rst_cpu_o    = out_q.cpu;
   assign ready_o      = out_q.ready;
   assign rst_cause_o  = cause_q;

endmodule
